fmlarb_rr4: RTL and testbench



---
 rtl/fmlarb_rr4.sv | 193 +++++++++++++++++++
 tb/tb_fmlarb_rr4.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fmlarb_rr4.sv
// fmlarb_rr4 -- four-master round-robin arbiter for one FML slave port.
//
// Grants the slave command phase to one master at a time, returns the slave
// early acknowledge to that master, muxes write data from the master that
// owns the current write burst, and pulses a per-master read acknowledge when
// that master's read burst starts returning READ_LAT cycles after its eack.
//
// Ports:
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   mN_adr/stb/we/sel/dw    master N command and write data (N = 0..3)
//   mN_eack                 master N command accepted (one cycle)
//   mN_rack                 master N first read beat (one cycle)
//   s_adr/stb/we/sel/dw     slave command and write data
//   s_eack                  slave early acknowledge
module fmlarb_rr4 #(
  parameter int ADR_W    = 26,
  parameter int DW       = 64,
  parameter int BURST    = 4,
  parameter int READ_LAT = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,

  input  logic [ADR_W-1:0] m0_adr,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [DW/8-1:0]  m0_sel,
  input  logic [DW-1:0]    m0_dw,
  output logic             m0_eack,
  output logic             m0_rack,

  input  logic [ADR_W-1:0] m1_adr,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [DW/8-1:0]  m1_sel,
  input  logic [DW-1:0]    m1_dw,
  output logic             m1_eack,
  output logic             m1_rack,

  input  logic [ADR_W-1:0] m2_adr,
  input  logic             m2_stb,
  input  logic             m2_we,
  input  logic [DW/8-1:0]  m2_sel,
  input  logic [DW-1:0]    m2_dw,
  output logic             m2_eack,
  output logic             m2_rack,

  input  logic [ADR_W-1:0] m3_adr,
  input  logic             m3_stb,
  input  logic             m3_we,
  input  logic [DW/8-1:0]  m3_sel,
  input  logic [DW-1:0]    m3_dw,
  output logic             m3_eack,
  output logic             m3_rack,

  output logic [ADR_W-1:0] s_adr,
  output logic             s_stb,
  output logic             s_we,
  input  logic             s_eack,
  output logic [DW/8-1:0]  s_sel,
  output logic [DW-1:0]    s_dw
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(BURST + 1);

  logic [ADR_W-1:0] adr_a [4];
  logic [SW-1:0]    sel_a [4];
  logic [DW-1:0]    dw_a  [4];
  logic [3:0]       stb_v;
  logic [3:0]       we_v;

  assign adr_a[0] = m0_adr;
  assign adr_a[1] = m1_adr;
  assign adr_a[2] = m2_adr;
  assign adr_a[3] = m3_adr;
  assign sel_a[0] = m0_sel;
  assign sel_a[1] = m1_sel;
  assign sel_a[2] = m2_sel;
  assign sel_a[3] = m3_sel;
  assign dw_a[0]  = m0_dw;
  assign dw_a[1]  = m1_dw;
  assign dw_a[2]  = m2_dw;
  assign dw_a[3]  = m3_dw;
  assign stb_v    = {m3_stb, m2_stb, m1_stb, m0_stb};
  assign we_v     = {m3_we, m2_we, m1_we, m0_we};

  logic                gv;
  logic [1:0]          g;
  logic [1:0]          last;
  logic [1:0]          wown;
  logic [CW-1:0]       wcnt;
  logic [READ_LAT-1:0] rd_vld;
  logic [1:0]          rd_id [READ_LAT];

  logic       mg_stb;
  logic       mg_we;
  logic       wblock;
  logic       acc;
  logic       win_vld;
  logic [1:0] win;
  logic [1:0] cand;

  assign mg_stb = stb_v[g];
  assign mg_we  = we_v[g];
  // A granted write waits until the previous burst is on its last beat, so
  // the next burst can follow without a gap but never overlaps.
  assign wblock = mg_we & (wcnt > CW'(1));
  assign acc    = gv & s_eack;

  assign s_stb = gv & mg_stb & ~wblock;
  assign s_we  = gv & mg_we;
  assign s_adr = gv ? adr_a[g] : '0;

  assign m0_eack = acc & (g == 2'd0);
  assign m1_eack = acc & (g == 2'd1);
  assign m2_eack = acc & (g == 2'd2);
  assign m3_eack = acc & (g == 2'd3);

  assign s_sel = (wcnt != '0) ? sel_a[wown] : '0;
  assign s_dw  = (wcnt != '0) ? dw_a[wown]  : '0;

  assign m0_rack = rd_vld[READ_LAT-1] & (rd_id[READ_LAT-1] == 2'd0);
  assign m1_rack = rd_vld[READ_LAT-1] & (rd_id[READ_LAT-1] == 2'd1);
  assign m2_rack = rd_vld[READ_LAT-1] & (rd_id[READ_LAT-1] == 2'd2);
  assign m3_rack = rd_vld[READ_LAT-1] & (rd_id[READ_LAT-1] == 2'd3);

  // Scan starts just after the last master served; i = 4 wraps to last
  // itself, so it is only chosen when nobody else is asking.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    cand    = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last + 2'(i);
      if (!win_vld && stb_v[cand]) begin
        win_vld = 1'b1;
        win     = cand;
      end
    end
  end

  // Grant register. A withdrawn request releases the grant but keeps last,
  // so the withdrawing master keeps its place in the rotation.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gv   <= 1'b0;
      g    <= 2'd0;
      last <= 2'd3;
    end else if (!gv) begin
      if (win_vld) begin
        gv <= 1'b1;
        g  <= win;
      end
    end else if (s_eack) begin
      gv   <= 1'b0;
      last <= g;
    end else if (!mg_stb) begin
      gv <= 1'b0;
    end
  end

  // Write data phase: wcnt counts the beats still to be driven from wown.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wcnt <= '0;
      wown <= 2'd0;
    end else if (acc & mg_we) begin
      wcnt <= CW'(BURST);
      wown <= g;
    end else if (wcnt != '0) begin
      wcnt <= wcnt - CW'(1);
    end
  end

  // Read return pipeline: stage 0 captures the acked read, last stage is
  // aligned with the first returning read beat.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rd_vld <= '0;
    end else begin
      rd_vld[0] <= acc & ~mg_we;
      for (int i = 1; i < READ_LAT; i++) rd_vld[i] <= rd_vld[i-1];
    end
  end

  // Read ids are qualified by rd_vld and need no reset.
  always_ff @(posedge sys_clk) begin
    rd_id[0] <= g;
    for (int i = 1; i < READ_LAT; i++) rd_id[i] <= rd_id[i-1];
  end

endmodule

// File: tb/tb_fmlarb_rr4.sv
module tb_fmlarb_rr4;

  localparam int ADR_W    = 26;
  localparam int DW       = 64;
  localparam int SW       = DW / 8;
  localparam int BURST    = 4;
  localparam int READ_LAT = 5;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [ADR_W-1:0] m_adr [4];
  logic [SW-1:0]    m_sel [4];
  logic [DW-1:0]    m_dw  [4];
  logic [3:0]       stb = 4'b0000;
  logic [3:0]       we  = 4'b0000;
  logic [3:0]       eack_v;
  logic [3:0]       rack_v;
  logic [ADR_W-1:0] s_adr;
  logic             s_stb;
  logic             s_we;
  logic             s_eack = 1'b0;
  logic [SW-1:0]    s_sel;
  logic [DW-1:0]    s_dw;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct { int cyc; logic [DW-1:0] dw; logic [SW-1:0] sel; } beat_t;
  typedef struct { int cyc; int id; } rack_t;
  beat_t beat_q[$];
  rack_t rack_q[$];

  fmlarb_rr4 #(.ADR_W(ADR_W), .DW(DW), .BURST(BURST), .READ_LAT(READ_LAT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_adr(m_adr[0]), .m0_stb(stb[0]), .m0_we(we[0]), .m0_sel(m_sel[0]), .m0_dw(m_dw[0]),
    .m0_eack(eack_v[0]), .m0_rack(rack_v[0]),
    .m1_adr(m_adr[1]), .m1_stb(stb[1]), .m1_we(we[1]), .m1_sel(m_sel[1]), .m1_dw(m_dw[1]),
    .m1_eack(eack_v[1]), .m1_rack(rack_v[1]),
    .m2_adr(m_adr[2]), .m2_stb(stb[2]), .m2_we(we[2]), .m2_sel(m_sel[2]), .m2_dw(m_dw[2]),
    .m2_eack(eack_v[2]), .m2_rack(rack_v[2]),
    .m3_adr(m_adr[3]), .m3_stb(stb[3]), .m3_we(we[3]), .m3_sel(m_sel[3]), .m3_dw(m_dw[3]),
    .m3_eack(eack_v[3]), .m3_rack(rack_v[3]),
    .s_adr(s_adr), .s_stb(s_stb), .s_we(s_we), .s_eack(s_eack),
    .s_sel(s_sel), .s_dw(s_dw)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write-beat and read-ack scoreboards, checked every cycle on the falling edge.
  always @(negedge sys_clk) begin : mon
    logic [DW-1:0] edw;
    logic [SW-1:0] esel;
    logic [3:0]    erk;
    edw  = '0;
    esel = '0;
    erk  = '0;
    if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
      edw  = beat_q[0].dw;
      esel = beat_q[0].sel;
      beat_q.delete(0);
    end
    if (rack_q.size() > 0 && rack_q[0].cyc == cyc) begin
      erk = 4'b0001 << rack_q[0].id;
      rack_q.delete(0);
    end
    check("wr_dw", s_dw, edw);
    check("wr_sel", s_sel, esel);
    check("rack", rack_v, erk);
  end

  task automatic next();
    @(posedge sys_clk);
    #1;
    s_eack = 1'b0;
  endtask

  // Called at +1 of a cycle: waits for s_stb, acks it, records expectations.
  task automatic serve(input int m, input bit drop, output int t);
    int n;
    logic [3:0] ev;
    n = 0;
    #1;
    while (s_stb !== 1'b1 && n < 40) begin
      next();
      #1;
      n++;
    end
    check("stb_timeout", (n < 40), 1'b1);
    t = cyc;
    if (n < 40) begin
      check("grant_adr", s_adr, m_adr[m]);
      check("grant_we", s_we, we[m]);
      s_eack = 1'b1;
      #1;
      ev = 4'b0001 << m;
      check("eack_vec", eack_v, ev);
      if (we[m]) begin
        for (int b = 1; b <= BURST; b++) beat_q.push_back('{t + b, m_dw[m], m_sel[m]});
      end else begin
        rack_q.push_back('{t + READ_LAT, m});
      end
    end
    next();
    if (drop) stb[m] = 1'b0;
  endtask

  initial begin
    int t, tp, c0;
    for (int i = 0; i < 4; i++) begin
      m_adr[i] = ADR_W'(32'h0AB_0000 + i * 32'h111);
      m_sel[i] = SW'(8'h11 << i);
      m_dw[i]  = {8'hD0 + 8'(i), 56'h12_3456_789A_BC00 + 56'(i)};
    end

    // Reset: outputs stay low even with a master requesting.
    stb[1] = 1'b1;
    next();
    next();
    #1;
    check("rst_stb", s_stb, 1'b0);
    check("rst_adr", s_adr, '0);
    check("rst_we", s_we, 1'b0);
    check("rst_eack", eack_v, 4'b0000);
    stb[1] = 1'b0;
    next();
    sys_rst = 1'b0;

    // Idle: nothing requested, nothing granted.
    for (int i = 0; i < 3; i++) begin
      next();
      #1;
      check("idle_stb", s_stb, 1'b0);
      check("idle_adr", s_adr, '0);
    end

    // Single master read from m2 with a slow slave.
    next();
    stb[2] = 1'b1;
    we[2]  = 1'b0;
    c0 = cyc;
    #1;
    check("arb_c0_stb", s_stb, 1'b0);
    next();
    #1;
    check("arb_c1_stb", s_stb, 1'b1);
    check("arb_c1_adr", s_adr, m_adr[2]);
    next();
    #1;
    check("arb_c2_stb", s_stb, 1'b1);
    next();
    s_eack = 1'b1;
    #1;
    check("single_eack", eack_v, 4'b0100);
    rack_q.push_back('{c0 + 3 + READ_LAT, 2});
    next();
    stb[2] = 1'b0;
    #1;
    check("single_eack_off", eack_v, 4'b0000);
    check("single_stb_off", s_stb, 1'b0);
    repeat (8) next();

    // Fairness: all four request reads continuously (last served was m2).
    stb = 4'b1111;
    we  = 4'b0000;
    tp  = 0;
    for (int k = 0; k < 8; k++) begin
      serve((3 + k) % 4, 1'b0, t);
      if (k > 0) check("rr_gap", t - tp, 2);
      tp = t;
    end
    stb = 4'b0000;
    repeat (8) next();

    // Back-to-back writes: m1 then m3, m3 held off until m1's last beat.
    we = 4'b1010;
    stb[1] = 1'b1;
    serve(1, 1'b1, tp);
    stb[3] = 1'b1;
    serve(3, 1'b1, t);
    check("wr_b2b_ack", t - tp, BURST);
    repeat (BURST + 4) next();

    // Mixed: m0 write, then m2 read acked while the burst streams.
    we = 4'b0001;
    stb[0] = 1'b1;
    serve(0, 1'b1, tp);
    stb[2] = 1'b1;
    serve(2, 1'b1, t);
    check("mixed_ack_gap", t - tp, 2);
    repeat (10) next();

    // Withdraw: m3 granted then drops stb; it must still win the next scan.
    we = 4'b0000;
    stb[3] = 1'b1;
    next();
    #1;
    check("wd_stb", s_stb, 1'b1);
    check("wd_adr", s_adr, m_adr[3]);
    next();
    stb[3] = 1'b0;
    #1;
    check("wd_drop_stb", s_stb, 1'b0);
    check("wd_drop_eack", eack_v, 4'b0000);
    next();
    stb[0] = 1'b1;
    stb[3] = 1'b1;
    serve(3, 1'b1, t);
    serve(0, 1'b1, t);
    repeat (8) next();

    // Reset two cycles after a read eack: its rack never appears.
    stb[1] = 1'b1;
    serve(1, 1'b1, t);
    next();
    sys_rst = 1'b1;
    rack_q.delete();
    beat_q.delete();
    #1;
    check("mrst_stb", s_stb, 1'b0);
    check("mrst_rack", rack_v, 4'b0000);
    next();
    next();
    sys_rst = 1'b0;
    repeat (8) next();
    stb = 4'b1111;
    for (int k = 0; k < 4; k++) serve(k, 1'b1, t);
    repeat (10) next();

    check("beat_q_empty", beat_q.size(), 0);
    check("rack_q_empty", rack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
